// File: rtl/lcd_cmd_seq.sv
`default_nettype none
//============================================================================
// Module   : lcd_cmd_seq
// Purpose  : Command sequencer in front of the LCD controller. Reads a
//            command script from a small synchronous ROM and hands the
//            commands to the controller one at a time. A command is issued
//            only while the controller is not busy. After the final Write
//            command, the sequencer waits for the controller's done.
//            It reports completion, the number of commands issued and a
//            sticky error flag.
// Ports    : clk, reset       - clock (rising edge), async active-high reset
//            start            - one-cycle request to run the script from 0
//            scr_a / scr_q    - script ROM address / data (1-cycle latency)
//                               scr_q[3] = last flag, scr_q[2:0] = command
//            busy / done      - controller handshake inputs
//            cmd / cmd_valid  - command code and its one-cycle strobe
//            seq_busy         - run in progress
//            seq_done/seq_err - sticky completion / error flags
//            cmd_cnt          - commands issued in the current run
// Options  : LCD_SEQ_TIMEOUT_EN - enables the TMO_CYC watchdog on every
//            waiting state. The parameter exists only in that build.
// Revision : 1.0 - initial release
//============================================================================
module lcd_cmd_seq #(
    parameter int SCR_AW = 5
`ifdef LCD_SEQ_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 1023
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [SCR_AW-1:0] scr_a,
    input  logic [3:0]        scr_q,
    input  logic              busy,
    input  logic              done,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [SCR_AW:0]   cmd_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RDY  = 3'd1,
        S_FETCH     = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    localparam logic [SCR_AW-1:0] C_LAST_ADDR = {SCR_AW{1'b1}};
    localparam logic [SCR_AW-1:0] C_ADDR_ONE  = {{(SCR_AW-1){1'b0}}, 1'b1};
    localparam logic [SCR_AW:0]   C_CNT_MAX   = {1'b1, {SCR_AW{1'b0}}};
    localparam logic [SCR_AW:0]   C_CNT_ONE   = {{SCR_AW{1'b0}}, 1'b1};

    state_t r_state;

`ifdef LCD_SEQ_TIMEOUT_EN
    // The exit is taken on the edge that completes the TMO_CYC-th waiting
    // cycle, so the count is compared against TMO_CYC-1.
    localparam logic [9:0] C_TMO_LAST = 10'(TMO_CYC - 1);
    localparam logic [9:0] C_WDOG_ONE = 10'd1;
    logic [9:0] r_wdog;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            scr_a     <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            seq_busy  <= 1'b0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
            cmd_cnt   <= '0;
`ifdef LCD_SEQ_TIMEOUT_EN
            r_wdog    <= '0;
`endif
        end else begin
            // The strobe lasts one cycle. cmd itself keeps its last value.
            cmd_valid <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
            // Cleared by default. Only the "stay and wait" branches count.
            r_wdog    <= '0;
`endif
            case (r_state)
                // FIN accepts a restart exactly like IDLE.
                S_IDLE, S_FIN: begin
                    if (start) begin
                        scr_a    <= '0;
                        cmd_cnt  <= '0;
                        seq_done <= 1'b0;
                        seq_err  <= 1'b0;
                        seq_busy <= 1'b1;
                        r_state  <= S_WAIT_RDY;
                    end
                end

                S_WAIT_RDY: begin
                    if (!busy) begin
                        r_state <= S_FETCH;
                    end else begin
`ifdef LCD_SEQ_TIMEOUT_EN
                        if (r_wdog == C_TMO_LAST) begin
                            r_state  <= S_FIN;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                            seq_err  <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog + C_WDOG_ONE;
                        end
`endif
                    end
                end

                // scr_a has been stable for a cycle, so scr_q is valid in ISSUE.
                S_FETCH: begin
                    r_state <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (busy) begin
`ifdef LCD_SEQ_TIMEOUT_EN
                        if (r_wdog == C_TMO_LAST) begin
                            r_state  <= S_FIN;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                            seq_err  <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog + C_WDOG_ONE;
                        end
`endif
                    end else begin
                        cmd       <= scr_q[2:0];
                        cmd_valid <= 1'b1;
                        if (cmd_cnt != C_CNT_MAX) begin
                            cmd_cnt <= cmd_cnt + C_CNT_ONE;
                        end
                        if (scr_q[2:0] == 3'd0) begin
                            r_state <= S_WAIT_DONE;
                        end else if (scr_q[3] || (scr_a == C_LAST_ADDR)) begin
                            // The script ran out before a Write command.
                            r_state  <= S_FIN;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                            seq_err  <= 1'b1;
                        end else begin
                            scr_a   <= scr_a + C_ADDR_ONE;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_WAIT_DONE: begin
                    if (done) begin
                        r_state  <= S_FIN;
                        seq_busy <= 1'b0;
                        seq_done <= 1'b1;
                    end else begin
`ifdef LCD_SEQ_TIMEOUT_EN
                        if (r_wdog == C_TMO_LAST) begin
                            r_state  <= S_FIN;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                            seq_err  <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog + C_WDOG_ONE;
                        end
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer directly upstream of the LCD controller.
- Fetches a stored command script from a small synchronous script ROM and drives the controller's cmd/cmd_valid inputs one command at a time, honouring the controller's busy handshake.
- Waits for the controller's done after the final Write (cmd 0).
- Reports completion, command count and a script/timeout error to the testbench or system top.

Parameters:
- SCR_AW, 5, script ROM address width (depth 2^SCR_AW = 32 entries).
- TMO_CYC, 1023, watchdog limit in clk cycles (used only when LCD_SEQ_TIMEOUT_EN is defined).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to run the script from entry 0.
- scr_a  output  SCR_AW  script ROM address.
- scr_q  input  4  script word: [3] = last flag, [2:0] = command code (0 Write, 1 Up, 2 Down, 3 Left, 4 Right, 5 Average, 6 Mirror-X, 7 Mirror-Y).
- busy  input  1  controller busy; commands accepted only while low.
- done  input  1  controller finished writing result image.
- cmd  output  3  command code to controller.
- cmd_valid  output  1  one-cycle command strobe.
- seq_busy  output  1  high from accepted start until FIN.
- seq_done  output  1  sticky completion flag.
- seq_err  output  1  sticky error flag, valid with seq_done.
- cmd_cnt  output  SCR_AW+1  number of commands issued in the current run.

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; scr_a=0.
- Script ROM timing: synchronous, 1-cycle read latency; scr_q reflects the scr_a registered in the previous cycle.
- States: IDLE, WAIT_RDY, FETCH, ISSUE, WAIT_DONE, FIN.
- IDLE:
  - start=1 → scr_a<=0, cmd_cnt<=0, seq_done<=0, seq_err<=0, seq_busy<=1 → WAIT_RDY.
- WAIT_RDY:
  - Waits for busy==0 (controller image load complete), then → FETCH.
- FETCH:
  - One cycle for ROM latency, then → ISSUE.
- ISSUE:
  - If busy==1: stall, cmd_valid=0, nothing changes.
  - Else: cmd<=scr_q[2:0], cmd_valid<=1 for exactly this one cycle, cmd_cnt<=cmd_cnt+1.
  - If scr_q[2:0]==0 (Write) → WAIT_DONE. Any script entries after the Write are never fetched.
  - Else if scr_q[3]==1 or scr_a==2^SCR_AW-1 → FIN with seq_err<=1 (script ended without Write).
  - Else scr_a<=scr_a+1 → FETCH.
  - Throughput: one command every 2 cycles; cmd_valid is never high on consecutive cycles.
- cmd between strobes: holds the last issued value. cmd_valid is the only qualifier.
- WAIT_DONE:
  - done==1 → FIN with seq_err unchanged.
- FIN:
  - seq_busy<=0, seq_done<=1; seq_done and seq_err stay sticky.
  - start=1 in FIN behaves exactly as in IDLE (restart).
- start:
  - Ignored while seq_busy=1.
  - start coinciding with a reset assertion: reset wins.
- done==1 seen outside WAIT_DONE: ignored.
- Reset mid-run: immediate return to reset values; no partial completion reported.
- cmd_cnt: saturates at 2^SCR_AW; never wraps.

Optional Feature:
- LCD_SEQ_TIMEOUT_EN defined:
  - A 10-bit watchdog counter is cleared on every state change and increments while in WAIT_RDY, ISSUE-stall or WAIT_DONE.
  - On reaching TMO_CYC → FIN with seq_err=1, seq_done=1.
- Undefined: no counter; the sequencer waits indefinitely and seq_err comes only from script termination.

Test Plan:
- Script {3, 1, 5, 0}, busy falls 70 cycles after start → cmd_valid pulses carry 3, 1, 5, 0 two cycles apart; cmd_cnt=4; seq_done=1 and seq_err=0 one cycle after done.
- Script {6, 0, 7} → only 6 and 0 issued; entry 2 is never fetched (scr_a never reaches 2); cmd_cnt=2.
- Script {4, 2|last} (word 0xA) → two pulses; FIN with seq_err=1 and no wait for done; cmd_cnt=2.
- Hold busy=1 for 5 cycles while in ISSUE → no cmd_valid during the stall; the command issues on the first busy=0 cycle; cmd_cnt increments once.
- Assert reset 3 cycles after the second pulse, then start again → all outputs 0 at reset; the rerun begins from scr_a=0 with cmd_cnt restarting at 0.
- With LCD_SEQ_TIMEOUT_EN and TMO_CYC=16, never assert done after Write → seq_done=1 and seq_err=1 exactly 16 cycles after entering WAIT_DONE.
